ntp_clock_selector: RTL and testbench
=====================================

# ntp_clock_selector

Selects which of the two NTP clock instances (A or B) drives the server's single timestamp bus, based on their sync and PLL-lock health. Sits between the two clock blocks and the packet timestamping logic, in the AXI clock domain. Uses debounced qualification, failover, optional revertive return to a preferred source, and a software force override. Flags any backward time step seen at a switch.

## Interface
Parameters:
- HOLDOFF_CYCLES, 1024: consecutive healthy cycles needed before a source is qualified; minimum 1.
- REVERTIVE, 1: 1 = return to the preferred source once it requalifies; 0 = stay on the current source while it is healthy.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_aresetn  in  1  asynchronous assert, active-low reset.
- sync_ok_a, pll_locked_a  in  1 each  clock A health inputs.
- ntp_time_a  in  64  clock A time (32.32 fixed point).
- ntp_time_upd_a  in  1  clock A time-update strobe.
- sync_ok_b, pll_locked_b, ntp_time_b, ntp_time_upd_b  in  1/1/64/1  same set for clock B.
- pref_sel  in  1  preferred source: 0 = A, 1 = B.
- force_en  in  1  when 1, selection is forced to force_sel.
- force_sel  in  1  forced source: 0 = A, 1 = B.
- backstep_clr  in  1  clears the backstep flag.
- ntp_time  out  64  selected time, registered.
- ntp_time_upd  out  1  selected update strobe, registered.
- sel  out  1  current source: 0 = A, 1 = B.
- sel_valid  out  1  high when the current source is healthy (state is not NO_SRC).
- switch_count  out  16  saturating count of source changes.
- backstep  out  1  sticky flag: a switch produced a backward time step.

## Operation
- healthy_x = sync_ok_x & pll_locked_x.
- qual_x comes from a per-source counter:
  - counter clears to 0 in any cycle where healthy_x = 0;
  - otherwise it increments, saturating at HOLDOFF_CYCLES;
  - qual_x = (counter == HOLDOFF_CYCLES).
- FSM states: NO_SRC, USE_A, USE_B. Reset state is NO_SRC.
- NO_SRC:
  - go to the preferred source if it is qualified;
  - otherwise go to the other source if it is qualified;
  - otherwise stay.
- USE_x, source x lost:
  - when healthy_x = 0 (raw, not debounced), go to USE_y if qual_y, else NO_SRC.
- USE_x, revertive return:
  - when REVERTIVE = 1, pref_sel selects y, qual_y = 1 and healthy_x = 1, go to USE_y.
- force_en = 1 overrides every rule above. Next state is USE_force_sel whatever the health of that source.
  - sel_valid then equals healthy of the forced source.
  - When force_en drops, the normal rules apply from the current state.
- If both sources fail in the same cycle, go to NO_SRC.
- switch_count increments on every entry into USE_A or USE_B from a different state (including from NO_SRC), saturating at 0xFFFF.
- Output path:
  - in USE_x: ntp_time <= ntp_time_x; ntp_time_upd <= ntp_time_upd_x;
  - in NO_SRC: ntp_time holds its value; ntp_time_upd <= 0.
- Backstep check:
  - applies on the first cycle in a new USE_x state;
  - if ntp_time_x < the last ntp_time value (unsigned 64-bit compare), set backstep;
  - backstep_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: ntp_time = 0, ntp_time_upd = 0, sel = 0, sel_valid = 0, switch_count = 0, backstep = 0, both qualifier counters = 0, state = NO_SRC.
- Qualification: first qual_x cycle comes HOLDOFF_CYCLES cycles after healthy_x rises. The state changes on the following edge.
- Loss: healthy_x falls in cycle n → state changes at edge n+1 → outputs follow at edge n+2.
- Outputs sel, sel_valid and ntp_time are registered from the current state. Input-to-output latency is 1 cycle.
- Strobes:
  - no strobe from the old source appears after the switch edge;
  - the new source's strobe passes starting in the first cycle of the new state.
- If reset asserts mid-operation, every output and state clears asynchronously. Qualification restarts from 0 after release.

## Structure
- Package ntps_pkg holds:
  - the state encoding localparams (NO_SRC = 2'd0, USE_A = 2'd1, USE_B = 2'd2);
  - SRC_A = 1'b0 and SRC_B = 1'b1.
- Sub-module ntp_src_qualifier (parameter HOLDOFF_CYCLES; inputs healthy; output qual) is instantiated twice. Its counter width is $clog2(HOLDOFF_CYCLES+1).

## Test plan
All scenarios use HOLDOFF_CYCLES = 8.
- Reset, then A healthy from cycle 0 with pref_sel = 0 → sel = 0, sel_valid = 1 at cycle 10, switch_count = 1.
- On A, sync_ok_a drops while B is qualified → sel = 1 two cycles later, switch_count = 2, no strobe from A after the switch edge.
- REVERTIVE = 1, on B, A healthy again → switch back to A after 8 healthy cycles plus 2. With REVERTIVE = 0 → stays on B.
- Both sources unhealthy in the same cycle → sel_valid = 0, ntp_time holds 0x0000_1234_0000_0000, ntp_time_upd = 0.
- Switch to a source whose time is 0x10 below the last output → backstep = 1. A backstep_clr pulse clears it. A forward switch leaves it at 0.
- force_en = 1, force_sel = 1 with B unhealthy → sel = 1, sel_valid = 0. Drop force_en with A qualified → returns to A.

Source files
------------

// File: rtl/ntp_clock_selector_pkg.sv
// Shared encodings for the NTP clock selector: FSM states and source ids.
package ntps_pkg;

  typedef enum logic [1:0] {
    NO_SRC = 2'd0,
    USE_A  = 2'd1,
    USE_B  = 2'd2
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [15:0] SWITCH_CNT_MAX = 16'hFFFF;

  function automatic state_e use_of(input logic src);
    if (src == SRC_B) return USE_B;
    return USE_A;
  endfunction

endpackage

// File: rtl/ntp_clock_selector_if.sv
// One NTP clock source as seen by the selector: health flags plus time bus.
interface ntp_clock_selector_if;
  logic        sync_ok;
  logic        pll_locked;
  logic [63:0] ntp_time;
  logic        ntp_time_upd;

  modport master (output sync_ok, output pll_locked, output ntp_time, output ntp_time_upd);
  modport slave  (input  sync_ok, input  pll_locked, input  ntp_time, input  ntp_time_upd);
endinterface

// File: rtl/ntp_src_qualifier.sv
// Debounce a raw health flag: qual asserts once healthy has held for HOLDOFF_CYCLES.
module ntp_src_qualifier #(
  parameter int unsigned HOLDOFF_CYCLES = 1024
) (
  input  logic axi_aclk,
  input  logic axi_aresetn,
  input  logic healthy,
  output logic qual
);

  localparam int unsigned CW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLDOFF_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (healthy) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign qual = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ntp_clock_selector.sv
// Picks clock A or B for the timestamp bus with debounced failover, optional
// revert to the preferred source, software force, and backward-step detection.
module ntp_clock_selector
  import ntps_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter bit          REVERTIVE      = 1'b1
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        sync_ok_a,
  input  logic        pll_locked_a,
  input  logic [63:0] ntp_time_a,
  input  logic        ntp_time_upd_a,
  input  logic        sync_ok_b,
  input  logic        pll_locked_b,
  input  logic [63:0] ntp_time_b,
  input  logic        ntp_time_upd_b,
  input  logic        pref_sel,
  input  logic        force_en,
  input  logic        force_sel,
  input  logic        backstep_clr,
  output logic [63:0] ntp_time,
  output logic        ntp_time_upd,
  output logic        sel,
  output logic        sel_valid,
  output logic [15:0] switch_count,
  output logic        backstep
);

  logic [1:0] healthy, qual, avail;

  assign healthy = {sync_ok_b & pll_locked_b, sync_ok_a & pll_locked_a};
  // A source that dropped this cycle still shows qual until its counter clears
  assign avail   = healthy & qual;

  for (genvar i = 0; i < 2; i++) begin : g_src
    ntp_src_qualifier #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_qual (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .healthy     (healthy[i]),
      .qual        (qual[i])
    );
  end

  state_e      state_q, state_d;
  logic        first_q, first_d;
  logic [63:0] time_q, time_d;
  logic        upd_q, upd_d;
  logic        sel_q, sel_d;
  logic        vld_q, vld_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bs_q, bs_d;

  always_comb begin
    state_d = state_q;
    if (force_en) begin
      state_d = use_of(force_sel);
    end else begin
      case (state_q)
        NO_SRC: begin
          if (avail[pref_sel])       state_d = use_of(pref_sel);
          else if (avail[~pref_sel]) state_d = use_of(~pref_sel);
        end
        USE_A: begin
          if (!healthy[SRC_A])
            state_d = avail[SRC_B] ? USE_B : NO_SRC;
          else if (REVERTIVE && pref_sel == SRC_B && avail[SRC_B])
            state_d = USE_B;
        end
        USE_B: begin
          if (!healthy[SRC_B])
            state_d = avail[SRC_A] ? USE_A : NO_SRC;
          else if (REVERTIVE && pref_sel == SRC_A && avail[SRC_A])
            state_d = USE_A;
        end
        default: state_d = NO_SRC;
      endcase
    end
  end

  logic        cur, active, switching, entering;
  logic [63:0] src_time;
  logic        src_upd;

  assign cur       = (state_q == USE_B);
  assign active    = (state_q != NO_SRC);
  assign switching = (state_d != state_q);
  assign entering  = switching && (state_d != NO_SRC);
  assign src_time  = cur ? ntp_time_b : ntp_time_a;
  assign src_upd   = cur ? ntp_time_upd_b : ntp_time_upd_a;

  always_comb begin
    first_d = entering;
    sel_d   = active ? cur : sel_q;
    vld_d   = active && (!force_en || healthy[cur]);
    time_d  = active ? src_time : time_q;
    // Drop the outgoing source's strobe in the cycle its state is being left
    upd_d   = active && !switching && src_upd;
    cnt_d   = (entering && cnt_q != SWITCH_CNT_MAX) ? cnt_q + 16'd1 : cnt_q;
    bs_d    = bs_q & ~backstep_clr;
    if (first_q && active && (src_time < time_q)) bs_d = 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= NO_SRC;
      first_q <= 1'b0;
      time_q  <= '0;
      upd_q   <= 1'b0;
      sel_q   <= SRC_A;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      bs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      time_q  <= time_d;
      upd_q   <= upd_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      bs_q    <= bs_d;
    end
  end

  assign ntp_time     = time_q;
  assign ntp_time_upd = upd_q;
  assign sel          = sel_q;
  assign sel_valid    = vld_q;
  assign switch_count = cnt_q;
  assign backstep     = bs_q;

endmodule

// File: tb/tb_ntp_clock_selector.sv
// Directed bench: a revertive and a non-revertive selector share one stimulus.
module tb_ntp_clock_selector;

  localparam logic [63:0] T_A1   = 64'h0000_1000_0000_0000;
  localparam logic [63:0] T_B1   = 64'h0000_2000_0000_0000;
  localparam logic [63:0] T_A3   = 64'h0000_3000_0000_0000;
  localparam logic [63:0] T_HOLD = 64'h0000_1234_0000_0000;
  localparam logic [63:0] T_JUNK = 64'h0000_FFFF_0000_0000;
  localparam logic [63:0] T_A5   = 64'h0000_1233_FFFF_FFF0;

  logic gclk = 1'b0;
  logic grst_n;
  logic pref_sel, force_en, force_sel, backstep_clr;

  ntp_clock_selector_if src_a ();
  ntp_clock_selector_if src_b ();

  logic [63:0] r_time, n_time;
  logic        r_upd, n_upd, r_sel, n_sel, r_vld, n_vld, r_bs, n_bs;
  logic [15:0] r_cnt, n_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  ntp_clock_selector #(.HOLDOFF_CYCLES(8), .REVERTIVE(1'b1)) u_dut_rev (
    .axi_aclk(gclk), .axi_aresetn(grst_n),
    .sync_ok_a(src_a.sync_ok), .pll_locked_a(src_a.pll_locked),
    .ntp_time_a(src_a.ntp_time), .ntp_time_upd_a(src_a.ntp_time_upd),
    .sync_ok_b(src_b.sync_ok), .pll_locked_b(src_b.pll_locked),
    .ntp_time_b(src_b.ntp_time), .ntp_time_upd_b(src_b.ntp_time_upd),
    .pref_sel(pref_sel), .force_en(force_en), .force_sel(force_sel),
    .backstep_clr(backstep_clr),
    .ntp_time(r_time), .ntp_time_upd(r_upd), .sel(r_sel), .sel_valid(r_vld),
    .switch_count(r_cnt), .backstep(r_bs)
  );

  ntp_clock_selector #(.HOLDOFF_CYCLES(8), .REVERTIVE(1'b0)) u_dut_nrev (
    .axi_aclk(gclk), .axi_aresetn(grst_n),
    .sync_ok_a(src_a.sync_ok), .pll_locked_a(src_a.pll_locked),
    .ntp_time_a(src_a.ntp_time), .ntp_time_upd_a(src_a.ntp_time_upd),
    .sync_ok_b(src_b.sync_ok), .pll_locked_b(src_b.pll_locked),
    .ntp_time_b(src_b.ntp_time), .ntp_time_upd_b(src_b.ntp_time_upd),
    .pref_sel(pref_sel), .force_en(force_en), .force_sel(force_sel),
    .backstep_clr(backstep_clr),
    .ntp_time(n_time), .ntp_time_upd(n_upd), .sel(n_sel), .sel_valid(n_vld),
    .switch_count(n_cnt), .backstep(n_bs)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  initial begin
    grst_n = 1'b0;
    pref_sel = 1'b0; force_en = 1'b0; force_sel = 1'b0; backstep_clr = 1'b0;
    src_a.sync_ok = 1'b0; src_a.pll_locked = 1'b0; src_a.ntp_time = '0; src_a.ntp_time_upd = 1'b0;
    src_b.sync_ok = 1'b0; src_b.pll_locked = 1'b0; src_b.ntp_time = '0; src_b.ntp_time_upd = 1'b0;

    #12;
    chk("rst_time", r_time, 0);
    chk("rst_upd", r_upd, 0);
    chk("rst_sel", r_sel, 0);
    chk("rst_vld", r_vld, 0);
    chk("rst_cnt", r_cnt, 0);
    chk("rst_bs", r_bs, 0);
    @(posedge gclk); #1;
    grst_n = 1'b1;

    // Both sources healthy from cycle 0; preferred A wins at cycle 10
    src_a.sync_ok = 1'b1; src_a.pll_locked = 1'b1; src_a.ntp_time = T_A1;
    src_b.sync_ok = 1'b1; src_b.pll_locked = 1'b1; src_b.ntp_time = T_B1;
    tick(9);
    chk("s1_vld_early", r_vld, 0);
    tick(1);
    chk("s1_sel", r_sel, 0);
    chk("s1_vld", r_vld, 1);
    chk("s1_cnt", r_cnt, 1);
    chk("s1_time", r_time, T_A1);
    chk("s1_n_cnt", n_cnt, 1);

    // A loses sync; failover to qualified B, A's strobe must not leak
    src_a.ntp_time_upd = 1'b1;
    tick(1);
    chk("s2_upd_a", r_upd, 1);
    src_a.sync_ok = 1'b0;
    tick(1);
    chk("s2_upd_gate", r_upd, 0);
    chk("s2_sel_hold", r_sel, 0);
    tick(1);
    chk("s2_sel", r_sel, 1);
    chk("s2_cnt", r_cnt, 2);
    chk("s2_time", r_time, T_B1);
    chk("s2_upd_none", r_upd, 0);
    chk("s2_bs", r_bs, 0);
    chk("s2_n_sel", n_sel, 1);
    src_b.ntp_time_upd = 1'b1;
    tick(1);
    chk("s2_upd_b", r_upd, 1);
    src_a.ntp_time_upd = 1'b0; src_b.ntp_time_upd = 1'b0;

    // A healthy again: revertive unit returns after 8+2, the other stays on B
    src_a.ntp_time = T_A3; src_a.sync_ok = 1'b1;
    tick(9);
    chk("s3_sel_early", r_sel, 1);
    tick(1);
    chk("s3_sel_rev", r_sel, 0);
    chk("s3_cnt_rev", r_cnt, 3);
    chk("s3_time_rev", r_time, T_A3);
    chk("s3_bs", r_bs, 0);
    chk("s3_n_sel", n_sel, 1);
    chk("s3_n_cnt", n_cnt, 2);

    // Both sources fail in the same cycle: time holds, no strobe
    src_a.ntp_time = T_HOLD; src_b.ntp_time = T_HOLD;
    tick(1);
    src_a.sync_ok = 1'b0; src_b.sync_ok = 1'b0;
    src_a.ntp_time_upd = 1'b1; src_b.ntp_time_upd = 1'b1;
    tick(1);
    src_a.ntp_time = T_JUNK; src_b.ntp_time = T_JUNK;
    tick(2);
    chk("s4_vld", r_vld, 0);
    chk("s4_time", r_time, T_HOLD);
    chk("s4_upd", r_upd, 0);
    chk("s4_cnt", r_cnt, 3);
    chk("s4_n_vld", n_vld, 0);
    chk("s4_n_time", n_time, T_HOLD);
    chk("s4_n_cnt", n_cnt, 2);

    // Re-enter on A whose time is 0x10 below the held output
    src_a.ntp_time_upd = 1'b0; src_b.ntp_time_upd = 1'b0;
    src_a.ntp_time = T_A5; src_a.sync_ok = 1'b1;
    tick(10);
    chk("s5_sel", r_sel, 0);
    chk("s5_vld", r_vld, 1);
    chk("s5_bs", r_bs, 1);
    chk("s5_cnt", r_cnt, 4);
    chk("s5_time", r_time, T_A5);
    chk("s5_n_bs", n_bs, 1);
    chk("s5_n_cnt", n_cnt, 3);
    backstep_clr = 1'b1;
    tick(1);
    backstep_clr = 1'b0;
    chk("s5_clr", r_bs, 0);
    chk("s5_n_clr", n_bs, 0);

    // Forward switch to B by changing preference
    src_b.ntp_time = T_B1; src_b.sync_ok = 1'b1; pref_sel = 1'b1;
    tick(10);
    chk("s5_fwd_sel", r_sel, 1);
    chk("s5_fwd_bs", r_bs, 0);
    chk("s5_fwd_cnt", r_cnt, 5);
    chk("s5_fwd_n_sel", n_sel, 0);
    chk("s5_fwd_n_cnt", n_cnt, 3);

    // Force onto unhealthy B
    pref_sel = 1'b0; force_en = 1'b1; force_sel = 1'b1; src_b.sync_ok = 1'b0;
    tick(2);
    chk("s6_sel", r_sel, 1);
    chk("s6_vld", r_vld, 0);
    chk("s6_cnt", r_cnt, 5);
    chk("s6_n_sel", n_sel, 1);
    chk("s6_n_vld", n_vld, 0);
    chk("s6_n_cnt", n_cnt, 4);
    chk("s6_n_bs", n_bs, 0);

    // Release force: back to A, which steps backward; set beats clear
    force_en = 1'b0; backstep_clr = 1'b1;
    tick(2);
    backstep_clr = 1'b0;
    chk("s6_ret_sel", r_sel, 0);
    chk("s6_ret_vld", r_vld, 1);
    chk("s6_set_wins", r_bs, 1);
    chk("s6_ret_cnt", r_cnt, 6);
    chk("s6_ret_n_sel", n_sel, 0);
    chk("s6_ret_n_bs", n_bs, 1);
    chk("s6_ret_n_cnt", n_cnt, 5);

    // Asynchronous reset mid-operation, then qualification restarts
    #3;
    grst_n = 1'b0;
    #1;
    chk("s7_rst_vld", r_vld, 0);
    chk("s7_rst_cnt", r_cnt, 0);
    chk("s7_rst_bs", r_bs, 0);
    chk("s7_rst_time", r_time, 0);
    chk("s7_rst_n_cnt", n_cnt, 0);
    @(posedge gclk); #1;
    grst_n = 1'b1;
    tick(9);
    chk("s7_vld_early", r_vld, 0);
    tick(1);
    chk("s7_vld", r_vld, 1);
    chk("s7_cnt", r_cnt, 1);
    chk("s7_time", r_time, T_A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
